// File: rtl/key_expansion_seq_if.sv
// key_expansion_seq_if: key-load request, status and round-key read bus of the AES key schedule.
// KEY_EXP_ZEROIZE_EN adds the zeroize request line.
interface key_expansion_seq_if #(parameter int KEY_W = 256);
  logic start;
  logic [1:0] key_len;
  logic [KEY_W-1:0] key;
  logic busy;
  logic done;
  logic err;
  logic [3:0] nr;
  logic [3:0] rk_idx;
  logic [127:0] rk;
`ifdef KEY_EXP_ZEROIZE_EN
  logic zeroize;
  modport master (output start, key_len, key, rk_idx, zeroize, input busy, done, err, nr, rk);
  modport slave (input start, key_len, key, rk_idx, zeroize, output busy, done, err, nr, rk);
`else
  modport master (output start, key_len, key, rk_idx, input busy, done, err, nr, rk);
  modport slave (input start, key_len, key, rk_idx, output busy, done, err, nr, rk);
`endif
endinterface

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: iterative AES-128/192/256 key schedule, one word per clock, indexed round-key read.
// KEY_EXP_ZEROIZE_EN adds a synchronous zeroize that wipes storage and aborts a run.
module key_expansion_seq #(
  parameter int MAX_NK = 8,
  parameter int KEY_W = 32 * MAX_NK
) (
  input logic clk,
  input logic rst_n,
  key_expansion_seq_if.slave bus
);
  localparam int NW = 4 * (MAX_NK + 7);
  localparam int AW = $clog2(NW);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;
  state_t state, state_nx;
  logic [31:0] w [NW];
  logic [KEY_W-1:0] key_q;
  logic [3:0] nk, nk_in, nr_in;
  logic [AW-1:0] i;
  logic [2:0] j;
  logic [7:0] rcon;
  logic bad, acc, rej, last, wrap, zero;
  logic [31:0] prev, sin, sub, t;
  logic [AW-1:0] base;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

`ifdef KEY_EXP_ZEROIZE_EN
  assign zero = bus.zeroize;
`else
  assign zero = 1'b0;
`endif

  assign nk_in = bus.key_len == 2'b00 ? 4'd4 : bus.key_len == 2'b01 ? 4'd6 : 4'd8;
  assign nr_in = nk_in + 4'd6;
  assign bad = bus.key_len == 2'b11 || nk_in > 4'(MAX_NK);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = zero ? IDLE
             : state == IDLE ? (acc ? LOAD : IDLE)
             : state == LOAD ? EXPAND
             : (last ? IDLE : EXPAND);
  end

  always_comb begin
    acc = !zero && state == IDLE && bus.start && !bad;
    rej = !zero && state == IDLE && bus.start && bad;
    last = state == EXPAND && i == AW'({bus.nr, 2'b11});
    bus.busy = state != IDLE;
  end

  // t folds RotWord/SubWord/rcon on period boundaries and the mid-period SubWord of 256-bit keys
  always_comb begin
    wrap = {1'b0, j} == nk - 4'd1;
    prev = w[i - AW'(1)];
    sin = j == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    sub = {sbox(sin[31:24]), sbox(sin[23:16]), sbox(sin[15:8]), sbox(sin[7:0])};
    t = j == 3'd0 ? sub ^ {rcon, 24'h0} : (nk == 4'd8 && j == 3'd4) ? sub : prev;
    base = {bus.rk_idx, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.nr <= 4'd10;
      bus.rk <= '0;
      nk <= 4'd4;
      i <= '0;
      j <= '0;
      rcon <= '0;
    end else begin
      bus.err <= rej;
      bus.done <= zero || acc ? 1'b0 : last ? 1'b1 : bus.done;
      if (acc) begin
        nk <= nk_in;
        bus.nr <= nr_in;
      end
      if (state == LOAD) begin
        i <= AW'(nk);
        j <= '0;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        i <= i + AW'(1);
        j <= wrap ? 3'd0 : j + 3'd1;
        rcon <= j == 3'd0 ? {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00) : rcon;
      end
      bus.rk <= zero || bus.rk_idx > bus.nr ? '0
              : {w[base], w[base + AW'(1)], w[base + AW'(2)], w[base + AW'(3)]};
    end

  // schedule storage has no reset; only zeroize clears it
  always_ff @(posedge clk) begin
    if (zero) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end else if (state == LOAD) begin
      for (int k = 0; k < MAX_NK; k++)
        if (k < int'(nk)) w[k] <= key_q[KEY_W-1-32*k -: 32];
    end else if (state == EXPAND) begin
      w[i] <= w[i - AW'(nk)] ^ t;
    end
    if (acc) key_q <= bus.key;
  end
endmodule
